// File: rtl/day006_timer_pkg.sv
// Shared types for the day006 timer: controller states and run modes.
package day006_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

endpackage

// File: rtl/day006_counter_core.sv
// Plain WIDTH-bit up counter with synchronous clear (clear wins over enable).
module day006_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             n_reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_reg;

    // Count register: clear has priority, otherwise advance by one when enabled.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            count_reg <= '0;
        end else if (clr_i) begin
            count_reg <= '0;
        end else if (en_i) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/day006_timer_ctrl.sv
// Timer controller: IDLE/RUN/PAUSE/DONE FSM around a counter core.
// The count runs 0..P and wraps, giving a registered tick every P+1 cycles;
// one-shot mode stops after the first tick and flags done for one cycle.
module day006_timer_ctrl
    import day006_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             n_reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] period_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] period_reg;
    mode_t            mode_reg;
    logic             tick_reg;
    logic             tick_next;
    logic             load;
    logic             cnt_en;
    logic             cnt_clr;
    logic             terminal;
    logic [WIDTH-1:0] count;

    day006_counter_core #(
        .WIDTH (WIDTH)
    ) u_counter_core (
        .clk_i     (clk_i),
        .n_reset_i (n_reset_i),
        .en_i      (cnt_en),
        .clr_i     (cnt_clr),
        .count_o   (count)
    );

    // The count never exceeds the latched period, so equality is the terminal test.
    assign terminal = (count == period_reg);

    // Next-state and datapath control. Priority while active: stop, pause, terminal, count.
    // PAUSE with pause released behaves exactly like RUN for that edge, so a
    // pause of N cycles delays the sequence by exactly N cycles.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        tick_next  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                cnt_clr = 1'b1;
                if (start_i) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN, PAUSE: begin
                if (stop_i) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (pause_i) begin
                    state_next = PAUSE;
                end else if (terminal) begin
                    cnt_clr    = 1'b1;
                    tick_next  = 1'b1;
                    state_next = (mode_reg == PERIODIC) ? RUN : DONE;
                end else begin
                    cnt_en     = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Period and mode are captured only when a start is accepted.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            period_reg <= '0;
            mode_reg   <= ONE_SHOT;
        end else if (load) begin
            period_reg <= period_i;
            mode_reg   <= mode_t'(mode_i);
        end
    end

    // Registered tick pulse, one cycle per terminal count.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= tick_next;
        end
    end

    assign count_o = count;
    assign tick_o  = tick_reg;
    assign busy_o  = (state_reg == RUN) || (state_reg == PAUSE);
    assign done_o  = (state_reg == DONE);

endmodule

// File: tb/tb_day006_timer_ctrl.sv
// Self-checking bench for day006_timer_ctrl: directed scenarios followed by
// random stimulus, all compared against a behavioural timer model.
module tb_day006_timer_ctrl;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         n_reset_i;
    logic         start_i;
    logic         stop_i;
    logic         pause_i;
    logic         mode_i;
    logic [W-1:0] period_i;
    logic [W-1:0] count_o;
    logic         tick_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: "active" timer with an elapsed count, plus the
    // one-cycle tick and done flags it produced on the last edge.
    bit m_active;
    bit m_done;
    bit m_tick;
    bit m_periodic;
    int m_period;
    int m_cnt;

    day006_timer_ctrl #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .n_reset_i (n_reset_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .pause_i   (pause_i),
        .mode_i    (mode_i),
        .period_i  (period_i),
        .count_o   (count_o),
        .tick_o    (tick_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        m_active   = 1'b0;
        m_done     = 1'b0;
        m_tick     = 1'b0;
        m_periodic = 1'b0;
        m_period   = 0;
        m_cnt      = 0;
    endfunction

    function automatic void model_edge(bit s, bit st, bit pa, bit mo, int pe);
        bit new_tick = 1'b0;
        bit new_done = 1'b0;
        if (m_active) begin
            if (st) begin
                m_active = 1'b0;
                m_cnt    = 0;
            end else if (pa) begin
                // frozen
            end else if (m_cnt == m_period) begin
                m_cnt    = 0;
                new_tick = 1'b1;
                if (!m_periodic) begin
                    m_active = 1'b0;
                    new_done = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (s) begin
            m_period   = pe;
            m_periodic = mo;
            m_cnt      = 0;
            m_active   = 1'b1;
        end
        m_tick = new_tick;
        m_done = new_done;
    endfunction

    task automatic check_outputs(input string tag);
        logic [W-1:0] exp_cnt;
        exp_cnt = m_cnt[W-1:0];
        checks++;
        assert (count_o === exp_cnt) else begin
            errors++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, count_o, exp_cnt);
        end
        checks++;
        assert (tick_o === m_tick) else begin
            errors++;
            $error("FAIL %s tick observed=%b expected=%b", tag, tick_o, m_tick);
        end
        checks++;
        assert (busy_o === m_active) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy_o, m_active);
        end
        checks++;
        assert (done_o === m_done) else begin
            errors++;
            $error("FAIL %s done observed=%b expected=%b", tag, done_o, m_done);
        end
    endtask

    // One clock cycle: drive inputs, take the edge, update the model, check.
    task automatic cyc(input string tag, input bit s = 1'b0, input bit st = 1'b0,
                       input bit pa = 1'b0, input bit mo = 1'b0, input int pe = 0);
        start_i  = s;
        stop_i   = st;
        pause_i  = pa;
        mode_i   = mo;
        period_i = pe[W-1:0];
        @(posedge clk_i);
        model_edge(s, st, pa, mo, pe);
        #1;
        check_outputs(tag);
        @(negedge clk_i);
    endtask

    initial begin
        // Reset held 20 ns with start high: everything stays cleared.
        n_reset_i = 1'b0;
        start_i   = 1'b1;
        stop_i    = 1'b0;
        pause_i   = 1'b0;
        mode_i    = 1'b1;
        period_i  = 4'd9;
        model_reset();
        #17;
        check_outputs("reset");
        @(negedge clk_i);
        n_reset_i = 1'b1;

        // Start on the first edge after reset: periodic P=3.
        cyc("per3_start", 1'b1, 1'b0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 10; i++) cyc("per3");
        // Start during RUN with period 7 must be ignored.
        cyc("ign_start", 1'b1, 1'b0, 1'b0, 1'b0, 7);
        for (int i = 0; i < 9; i++) cyc("per3_after");
        cyc("stop", 1'b0, 1'b1);
        cyc("idle");

        // One-shot P=2.
        cyc("os2_start", 1'b1, 1'b0, 1'b0, 1'b0, 2);
        for (int i = 0; i < 5; i++) cyc("os2");

        // Pause 3 cycles at count 2 with periodic P=5.
        cyc("p5_start", 1'b1, 1'b0, 1'b0, 1'b1, 5);
        for (int i = 0; i < 2; i++) cyc("p5_run");
        for (int i = 0; i < 3; i++) cyc("p5_pause", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("p5_resume");
        cyc("p5_stop", 1'b0, 1'b1);

        // Stop on the terminal-count cycle, periodic P=4.
        cyc("p4_start", 1'b1, 1'b0, 1'b0, 1'b1, 4);
        for (int i = 0; i < 4; i++) cyc("p4_run");
        cyc("p4_stop_term", 1'b0, 1'b1);
        cyc("p4_after");

        // Pause asserted exactly on the terminal count: no tick while paused.
        cyc("p1_start", 1'b1, 1'b0, 1'b0, 1'b1, 1);
        cyc("p1_run");
        for (int i = 0; i < 2; i++) cyc("p1_pause_term", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("p1_resume");
        cyc("p1_stop", 1'b0, 1'b1);

        // P=0 periodic: tick every cycle, count stays 0.
        cyc("p0_per_start", 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) cyc("p0_per");
        cyc("p0_per_stop", 1'b0, 1'b1);

        // P=0 one-shot: single tick then done.
        cyc("p0_os_start", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc("p0_os");

        // Start held while in DONE re-enters RUN with the new settings.
        cyc("os1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1);
        cyc("os1_run");
        cyc("os1_term");
        cyc("done_restart", 1'b1, 1'b0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 6; i++) cyc("restart_run");
        cyc("restart_stop", 1'b0, 1'b1);

        // Asynchronous reset in the middle of a run discards it.
        cyc("mid_start", 1'b1, 1'b0, 1'b0, 1'b1, 6);
        for (int i = 0; i < 3; i++) cyc("mid_run");
        #2;
        n_reset_i = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk_i);
        @(negedge clk_i);
        n_reset_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc("post_reset");

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/day006_timer_ctrl.md
DAY006_TIMER_CTRL -- requirements
Module: day006_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the counter datapath, period_i and count_o.
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port n_reset_i  input  1  reset: asynchronous and active-low.
REQ-004 SHALL have port start_i  input  1  start request; accepted only in IDLE or DONE.
REQ-005 SHALL have port stop_i  input  1  abort request; honoured in RUN or PAUSE.
REQ-006 SHALL have port pause_i  input  1  level: freeze the count while high in RUN.
REQ-007 SHALL have port mode_i  input  1  0 = one-shot, 1 = periodic; sampled with start_i.
REQ-008 SHALL have port period_i  input  WIDTH  terminal count P; sampled with start_i.
REQ-009 SHALL have port count_o  output  WIDTH  current counter value.
REQ-010 SHALL have port tick_o  output  1  registered one-cycle pulse per terminal count.
REQ-011 SHALL have port busy_o  output  1  high in RUN and PAUSE.
REQ-012 SHALL have port done_o  output  1  high for exactly one cycle when a one-shot completes.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL, on a start_i edge in IDLE or DONE: latch period_q = period_i and mode_q = mode_i, clear the count to 0, and enter RUN.
REQ-015 SHALL ignore start_i in RUN and PAUSE; the latched period and mode stay unchanged.
REQ-016 SHALL, in RUN with pause_i low, increment the count by 1 each edge while count != period_q.
REQ-017 SHALL, in RUN when count == period_q: set the count to 0 and pulse tick_o on the next cycle; this gives a tick period of P+1 cycles.
REQ-018 SHALL, on the terminal count in one-shot mode, enter DONE in the same edge as the tick.
REQ-019 SHALL, on the terminal count in periodic mode, remain in RUN.
REQ-020 SHALL hold DONE for one cycle, then enter IDLE unless start_i is high, in which case it re-enters RUN per REQ-014.
REQ-021 SHALL treat P = 0 as a legal period.
REQ-022 SHALL, for P = 0 in periodic mode, produce tick_o on every cycle after start while count_o stays 0.
REQ-023 SHALL, for P = 0 in one-shot mode, produce a single tick followed by DONE.
REQ-024 SHALL, on pause_i high in RUN, enter PAUSE, hold the count and suppress tick_o.
REQ-025 SHALL, on pause_i low in PAUSE, return to RUN and resume from the held count.
REQ-026 SHALL give stop_i priority over pause_i and over the terminal count: next state IDLE, count 0, no tick_o, no done_o.
REQ-027 SHALL give pause_i priority over the terminal count, so no tick is produced while paused.
REQ-028 SHALL keep count_o at 0 in IDLE and DONE.
REQ-029 SHALL wrap the count only via REQ-017; it never overflows because period_q <= 2^WIDTH-1.
REQ-030 SHALL drive done_o and busy_o directly from the registered state; no combinational path from any input to any output.

Reset
REQ-031 SHALL, while n_reset_i is low, immediately force: state IDLE, count_o 0, tick_o 0, done_o 0, busy_o 0, period_q 0, mode_q 0.
REQ-032 SHALL, when reset asserts mid-RUN, discard the operation; no tick_o or done_o is produced for it.
REQ-033 SHALL, after reset deasserts, act on start_i from the first rising edge.

Structure
REQ-034 SHALL take the state enum (IDLE, RUN, PAUSE, DONE) and the mode enum (ONE_SHOT, PERIODIC) from package day006_timer_pkg.
REQ-035 SHALL instantiate one sub-module, day006_counter_core: a WIDTH-bit up counter with ports clk_i, n_reset_i, en_i, clr_i and count_o.
REQ-036 SHALL place the FSM, the period/mode registers, the compare logic and the tick/done registers in day006_timer_ctrl.

Verification
REQ-037 SHALL cover reset: hold n_reset_i low for 20 ns with start_i high -> all outputs 0, state IDLE.
REQ-038 SHALL cover periodic P=3: start -> count_o sequence 0,1,2,3,0,...; tick_o one cycle high every 4 cycles; busy_o high throughout; done_o never high.
REQ-039 SHALL cover one-shot P=2: start -> count_o 0,1,2,0; one tick_o pulse and done_o in the same cycle; busy_o low after; IDLE 1 cycle later.
REQ-040 SHALL cover pause: periodic P=5, pause_i high for 3 cycles at count 2 -> count_o holds 2 for those cycles, then resumes at 3; tick delayed by 3 cycles.
REQ-041 SHALL cover stop vs terminal: periodic P=4, stop_i high in the cycle count_o = 4 -> no tick_o, count_o 0, busy_o 0 next cycle.
REQ-042 SHALL cover edge cases: P=0 periodic -> tick_o high every cycle after start; start_i during RUN with period_i=7 -> ignored, period stays 3.
